// File: rtl/mem_initiator.sv
// Bus-master side of the CPU memory interface.
// Arbitrates fetch and load/store clients (data first), drives one mmu
// transfer at a time and returns a one-cycle ack to the owner. A watchdog
// aborts transfers that never see a matching ready and reports them via err.
//
// Handshake: each client holds its req level until it sees its ack. Requests
// are sampled only in IDLE. The ack, err and data outputs are valid for the
// single DONE cycle and read zero otherwise. Towards the mmu, m_read/m_write
// stay high until the matching ready pulse (or the watchdog) ends the
// transfer, and then stay low for at least two cycles.
module mem_initiator #(
    parameter int TIMEOUT = 64,
    parameter int AW      = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic [1:0]    f_count,
    output logic          f_ack,
    output logic [31:0]   f_data,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [1:0]    d_count,
    input  logic [31:0]   d_wdata,
    input  logic          d_signed,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          f_err,
    output logic [AW-1:0] m_address,
    output logic          m_read,
    output logic          m_write,
    output logic [1:0]    m_byteCount,
    output logic [31:0]   m_dataIn,
    input  logic [31:0]   m_dataOut,
    input  logic          m_dataOutReady,
    input  logic          m_dataInReady,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_d_q, own_d_d;   // 1: data client owns the transfer
    logic          we_q, we_d;         // 1: store
    logic          sgn_q, sgn_d;       // sign-extend the load result

    logic          hit;                // ready matching the transfer kind
    logic          expired;            // watchdog reached its last cycle
    logic [31:0]   rd_value;           // extended read data for this cycle

    logic          f_ack_n, f_err_n, d_ack_n, d_err_n;
    logic [31:0]   f_data_n, d_rdata_n, m_dataIn_n;
    logic [AW-1:0] m_address_n;
    logic [1:0]    m_byteCount_n;
    logic          m_read_n, m_write_n, busy_n;

    // Widen a read result from count+1 bytes, replicating the top byte's MSB
    // when s is set, otherwise filling with zeros.
    function automatic logic [31:0] extend(input logic [31:0] v,
                                           input logic [1:0]  c,
                                           input logic        s);
        logic [31:0] r;
        case (c)
            2'd0:    r = {{24{s & v[7]}},  v[7:0]};
            2'd1:    r = {{16{s & v[15]}}, v[15:0]};
            2'd2:    r = {{8{s & v[23]}},  v[23:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    assign dbg_state = state_q;

    // Next-state and next-output logic; every registered output is computed here.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        own_d_d       = own_d_q;
        we_d          = we_q;
        sgn_d         = sgn_q;
        m_address_n   = m_address;
        m_byteCount_n = m_byteCount;
        m_dataIn_n    = m_dataIn;
        m_read_n      = m_read;
        m_write_n     = m_write;
        f_ack_n       = 1'b0;
        f_err_n       = 1'b0;
        f_data_n      = '0;
        d_ack_n       = 1'b0;
        d_err_n       = 1'b0;
        d_rdata_n     = '0;

        hit      = we_q ? m_dataInReady : m_dataOutReady;
        expired  = (cnt_q == CW'(TIMEOUT - 1));
        rd_value = (!we_q && hit) ? extend(m_dataOut, m_byteCount, sgn_q) : '0;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    own_d_d       = 1'b1;
                    we_d          = d_we;
                    sgn_d         = d_signed & ~d_we;
                    m_address_n   = d_addr;
                    m_byteCount_n = d_count;
                    m_dataIn_n    = d_we ? d_wdata : '0;
                    m_read_n      = ~d_we;
                    m_write_n     = d_we;
                    cnt_d         = '0;
                    state_d       = WAIT;
                end else if (f_req) begin
                    own_d_d       = 1'b0;
                    we_d          = 1'b0;
                    sgn_d         = 1'b0;
                    m_address_n   = f_addr;
                    m_byteCount_n = f_count;
                    m_dataIn_n    = '0;
                    m_read_n      = 1'b1;
                    m_write_n     = 1'b0;
                    cnt_d         = '0;
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (hit || expired) begin
                    m_read_n  = 1'b0;
                    m_write_n = 1'b0;
                    state_d   = DONE;
                    if (own_d_q) begin
                        d_ack_n   = 1'b1;
                        d_err_n   = ~hit;
                        d_rdata_n = rd_value;
                    end else begin
                        f_ack_n  = 1'b1;
                        f_err_n  = ~hit;
                        f_data_n = rd_value;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_n = (state_d != IDLE);
    end

    // State, latched request and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            own_d_q     <= 1'b0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            m_address   <= '0;
            m_byteCount <= '0;
            m_dataIn    <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            f_ack       <= 1'b0;
            f_err       <= 1'b0;
            f_data      <= '0;
            d_ack       <= 1'b0;
            d_err       <= 1'b0;
            d_rdata     <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            own_d_q     <= own_d_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            m_address   <= m_address_n;
            m_byteCount <= m_byteCount_n;
            m_dataIn    <= m_dataIn_n;
            m_read      <= m_read_n;
            m_write     <= m_write_n;
            f_ack       <= f_ack_n;
            f_err       <= f_err_n;
            f_data      <= f_data_n;
            d_ack       <= d_ack_n;
            d_err       <= d_err_n;
            d_rdata     <= d_rdata_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: a byte-addressed mmu responder with a
// configurable hang, a memory model predicting every ack, one compare process
// checking ack/err/data every cycle, and hand-computed literal expectations.
module tb_mem_initiator;

    logic        clk, rst;
    logic        f_req, f_ack, f_err;
    logic [23:0] f_addr;
    logic [1:0]  f_count;
    logic [31:0] f_data;
    logic        d_req, d_we, d_signed, d_ack, d_err;
    logic [23:0] d_addr;
    logic [1:0]  d_count;
    logic [31:0] d_wdata, d_rdata;
    logic [23:0] m_address;
    logic        m_read, m_write;
    logic [1:0]  m_byteCount;
    logic [31:0] m_dataIn, m_dataOut;
    logic        m_dataOutReady, m_dataInReady, busy;
    logic [1:0]  dbg_state;

    mem_initiator #(.TIMEOUT(64), .AW(24)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_count(f_count),
        .f_ack(f_ack), .f_data(f_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_count(d_count),
        .d_wdata(d_wdata), .d_signed(d_signed),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .f_err(f_err),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_byteCount(m_byteCount), .m_dataIn(m_dataIn),
        .m_dataOut(m_dataOut), .m_dataOutReady(m_dataOutReady),
        .m_dataInReady(m_dataInReady),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not finish");
    end

    // ---------------- memories ----------------
    logic [7:0] mmu_mem [0:4095];   // responder storage
    logic [7:0] ref_mem [0:4095];   // model storage, updated in program order

    // ---------------- mmu responder ----------------
    // Post-edge view: a request seen after edge E is set up at E+1, moves
    // count+1 bytes and pulses ready right after edge E+count+2. It also
    // pulses the wrong-kind ready, which the initiator must ignore.
    bit          hung = 1'b0;
    bit          mmu_unstable;
    logic [23:0] last_wr_addr;
    logic [31:0] last_wr_data, last_rd_din;
    initial begin
        int          mstate, left;
        bit          r, mwe;
        logic [23:0] maddr;
        logic [1:0]  mcnt;
        logic [31:0] mwd, v;
        logic [11:0] ix;
        m_dataOut = 32'hDEAD_BEEF; m_dataOutReady = 1'b0; m_dataInReady = 1'b0;
        mstate = 0; left = 0; mmu_unstable = 1'b0;
        last_wr_addr = '0; last_wr_data = '0; last_rd_din = '1;
        forever begin
            @(posedge clk);
            r = rst;
            #1;
            m_dataOutReady = 1'b0; m_dataInReady = 1'b0; m_dataOut = 32'hDEAD_BEEF;
            if (r) begin
                mstate = 0;
            end else begin
                case (mstate)
                    0: if (m_read || m_write) begin
                        mwe = m_write; maddr = m_address; mcnt = m_byteCount; mwd = m_dataIn;
                        if (m_write) begin last_wr_addr = m_address; last_wr_data = m_dataIn; end
                        else last_rd_din = m_dataIn;
                        left = int'(m_byteCount) + 2;
                        mstate = hung ? 2 : 1;
                    end
                    1: begin
                        if (m_address !== maddr || m_byteCount !== mcnt || m_dataIn !== mwd ||
                            m_write !== mwe || m_read !== !mwe) mmu_unstable = 1'b1;
                        left--;
                        if (left == 1) begin
                            if (mwe) m_dataOutReady = 1'b1; else m_dataInReady = 1'b1;
                        end
                        if (left == 0) begin
                            v = '0;
                            for (int i = 0; i <= int'(mcnt); i++) begin
                                ix = maddr[11:0] + 12'(i);
                                if (mwe) mmu_mem[ix] = mwd[8*i +: 8];
                                else v[8*i +: 8] = mmu_mem[ix];
                            end
                            if (mwe) m_dataInReady = 1'b1;
                            else begin m_dataOut = v; m_dataOutReady = 1'b1; end
                            mstate = 2;
                        end
                    end
                    default: begin
                        if (!m_read && !m_write) mstate = 0;
                        else if (hung && m_read) m_dataInReady = 1'b1;
                    end
                endcase
            end
        end
    end

    // ---------------- model / scoreboard ----------------
    logic [32:0] exp_d_q[$];   // {err, data}
    logic [32:0] exp_f_q[$];
    int checks = 0, failures = 0, d_ack_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Read count+1 little-endian bytes; sign-extend from the top loaded bit.
    function automatic logic [32:0] predict_load(input logic [23:0] a, input logic [1:0] c,
                                                 input bit s);
        logic [63:0] v;
        logic [11:0] ix;
        int nb;
        v = '0;
        nb = 8 * (int'(c) + 1);
        for (int i = 0; i <= int'(c); i++) begin
            ix = a[11:0] + 12'(i);
            v = v + (64'(ref_mem[ix]) << (8 * i));
        end
        if (s && c != 2'd3 && v[nb-1]) v = v - (64'd1 << nb);
        return {1'b0, v[31:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic req_d(input bit we, input logic [23:0] a, input logic [1:0] c,
                         input logic [31:0] wd, input bit s, input bit exp_timeout);
        logic [11:0] ix;
        d_we = we; d_addr = a; d_count = c; d_wdata = wd; d_signed = s; d_req = 1'b1;
        if (exp_timeout) exp_d_q.push_back({1'b1, 32'h0});
        else if (we) begin
            for (int i = 0; i <= int'(c); i++) begin
                ix = a[11:0] + 12'(i);
                ref_mem[ix] = wd[8*i +: 8];
            end
            exp_d_q.push_back({1'b0, 32'h0});
        end else exp_d_q.push_back(predict_load(a, c, s));
    endtask

    task automatic req_f(input logic [23:0] a, input logic [1:0] c);
        f_addr = a; f_count = c; f_req = 1'b1;
        exp_f_q.push_back(predict_load(a, c, 1'b0));
    endtask

    task automatic wait_done(input bit want_d, input bit want_f, input bit drop,
                             output int dcyc, output int fcyc,
                             output logic [31:0] dd, output logic [31:0] fd,
                             output logic derr);
        bit got_d, got_f;
        int n;
        got_d = !want_d; got_f = !want_f; n = 0;
        dcyc = 0; fcyc = 0; dd = '0; fd = '0; derr = 1'b0;
        while (!(got_d && got_f) && n < 300) begin
            @(posedge clk); #1; n++;
            if (!got_d && d_ack) begin
                got_d = 1'b1; dcyc = cyc; dd = d_rdata; derr = d_err;
                if (drop) d_req = 1'b0;
            end
            if (!got_f && f_ack) begin
                got_f = 1'b1; fcyc = cyc; fd = f_data;
                f_req = 1'b0;
            end
        end
        chk("ack_within_budget", 64'(got_d && got_f), 64'd1);
        if (!(got_d && got_f)) begin d_req = 1'b0; f_req = 1'b0; end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    int          i0, dc, fc, dc1, acks_before;
    logic [31:0] dd, fd;
    logic        de;

    initial begin
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0; f_count = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_count = '0; d_wdata = '0; d_signed = 1'b0;
        for (int i = 0; i < 4096; i++) begin mmu_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
        mmu_mem[12'h100] = 8'h05; mmu_mem[12'h101] = 8'hBA;
        mmu_mem[12'h102] = 8'hAD; mmu_mem[12'h103] = 8'h05;
        mmu_mem[12'h104] = 8'hF0; mmu_mem[12'h105] = 8'h0D;
        for (int i = 0; i < 6; i++) ref_mem[12'h100 + 12'(i)] = mmu_mem[12'h100 + 12'(i)];

        // Compare process: every ack against the model, zeros outside acks.
        fork
            begin
                logic [32:0] e;
                bit prev_d, prev_f;
                prev_d = 1'b0; prev_f = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_d = 1'b0; prev_f = 1'b0;
                    end else begin
                        if (d_ack) begin
                            d_ack_cnt++;
                            chk("d_ack_expected", 64'(exp_d_q.size() != 0), 64'd1);
                            if (exp_d_q.size() != 0) begin
                                e = exp_d_q.pop_front();
                                chk("d_resp", 64'({d_err, d_rdata}), 64'(e));
                            end
                        end else chk("d_quiet", 64'({d_err, d_rdata}), 64'd0);
                        if (f_ack) begin
                            chk("f_ack_expected", 64'(exp_f_q.size() != 0), 64'd1);
                            if (exp_f_q.size() != 0) begin
                                e = exp_f_q.pop_front();
                                chk("f_resp", 64'({f_err, f_data}), 64'(e));
                            end
                        end else chk("f_quiet", 64'({f_err, f_data}), 64'd0);
                        chk("ack_pulse", 64'({d_ack & prev_d, f_ack & prev_f, d_ack & f_ack}), 64'd0);
                        chk("rw_exclusive", 64'(m_read & m_write), 64'd0);
                        prev_d = d_ack; prev_f = f_ack;
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({f_ack, f_err, d_ack, d_err, m_read, m_write, busy, dbg_state}), 64'd0);
        chk("rst_data", {f_data, d_rdata}, 64'd0);
        chk("rst_mbus", 64'({m_address, m_byteCount, m_dataIn}), 64'd0);
        rst = 1'b0;
        idle_cycle();

        // Fetch 0x100, 4 bytes: ack 6 cycles after accept
        i0 = cyc;
        req_f(24'h100, 2'd3);
        wait_done(1'b0, 1'b1, 1'b1, dc, fc, dd, fd, de);
        chk("fetch_data", 64'(fd), 64'h05ADBA05);
        chk("fetch_latency", 64'(fc - (i0 + 1)), 64'd6);
        chk("fetch_read_low_done", 64'(m_read), 64'd0);
        idle_cycle();
        chk("fetch_read_low_idle", 64'({m_read, busy}), 64'd0);

        // Store 0x80F0 to 0x010, then signed and unsigned halfword loads
        i0 = cyc;
        req_d(1'b1, 24'h010, 2'd1, 32'h0000_80F0, 1'b0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("store_latency", 64'(dc - i0), 64'd5);
        chk("store_bus", {8'h0, last_wr_addr, last_wr_data}, 64'h0000_0010_0000_80F0);
        idle_cycle();
        req_d(1'b0, 24'h010, 2'd1, 32'h0, 1'b1, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("load_signed_h", 64'(dd), 64'hFFFF80F0);
        idle_cycle();
        req_d(1'b0, 24'h010, 2'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("load_unsigned_h", 64'(dd), 64'h000080F0);
        chk("load_datain_zero", 64'(last_rd_din), 64'd0);
        idle_cycle();

        // Sign extension for byte and 3-byte loads
        req_d(1'b0, 24'h101, 2'd0, 32'h0, 1'b1, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("load_signed_b", 64'(dd), 64'hFFFFFFBA);
        idle_cycle();
        req_d(1'b0, 24'h100, 2'd2, 32'h0, 1'b1, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("load_signed_3b", 64'(dd), 64'hFFADBA05);
        idle_cycle();

        // Simultaneous requests: data first, fetch stays pending
        i0 = cyc;
        req_d(1'b0, 24'h101, 2'd0, 32'h0, 1'b0, 1'b0);
        req_f(24'h100, 2'd3);
        wait_done(1'b1, 1'b1, 1'b1, dc, fc, dd, fd, de);
        chk("both_d_data", 64'(dd), 64'h000000BA);
        chk("both_f_data", 64'(fd), 64'h05ADBA05);
        chk("both_d_latency", 64'(dc - i0), 64'd4);
        chk("both_f_latency", 64'(fc - i0), 64'd12);
        idle_cycle();

        // Hung responder: abort after 64 WAIT cycles with err
        hung = 1'b1;
        i0 = cyc;
        req_d(1'b0, 24'h020, 2'd0, 32'h0, 1'b0, 1'b1);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("timeout_latency", 64'(dc - i0), 64'd65);
        chk("timeout_err_data", 64'({de, dd}), 64'h1_0000_0000);
        chk("timeout_read_low", 64'(m_read), 64'd0);
        hung = 1'b0;
        idle_cycle();
        req_d(1'b0, 24'h104, 2'd1, 32'h0, 1'b0, 1'b0);
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("after_timeout", 64'({de, dd}), 64'h0_0000_0DF0);
        idle_cycle();

        // Reset in WAIT mid-read: silent abort
        f_addr = 24'h100; f_count = 2'd3; f_req = 1'b1;
        idle_cycle();
        idle_cycle();
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1; f_req = 1'b0;
        idle_cycle();
        chk("mid_rst_ctrl", 64'({f_ack, f_err, d_ack, d_err, m_read, m_write, busy, dbg_state}), 64'd0);
        chk("mid_rst_data", {f_data, d_rdata}, 64'd0);
        chk("mid_rst_mbus", 64'({m_address, m_byteCount, m_dataIn}), 64'd0);
        rst = 1'b0;
        idle_cycle();
        i0 = cyc;
        req_f(24'h104, 2'd1);
        wait_done(1'b0, 1'b1, 1'b1, dc, fc, dd, fd, de);
        chk("after_rst_fetch", 64'(fd), 64'h00000DF0);
        chk("after_rst_latency", 64'(fc - i0), 64'd5);
        idle_cycle();

        // Client holds d_req through DONE: exactly one extra transfer
        acks_before = d_ack_cnt;
        req_d(1'b0, 24'h100, 2'd0, 32'h0, 1'b0, 1'b0);
        exp_d_q.push_back(predict_load(24'h100, 2'd0, 1'b0));
        wait_done(1'b1, 1'b0, 1'b0, dc1, fc, dd, fd, de);
        chk("hold_first_data", 64'(dd), 64'h05);
        idle_cycle();
        chk("hold_no_dup_ack", 64'({d_ack, busy}), 64'd0);
        idle_cycle();
        chk("hold_extra_issued", 64'({busy, m_read}), 64'b11);
        d_req = 1'b0;
        wait_done(1'b1, 1'b0, 1'b1, dc, fc, dd, fd, de);
        chk("hold_second_gap", 64'(dc - dc1), 64'd5);
        repeat (10) @(posedge clk);
        #1;
        chk("hold_ack_count", 64'(d_ack_cnt - acks_before), 64'd2);

        // Closing checks
        chk("mmu_req_stable", 64'(mmu_unstable), 64'd0);
        chk("queues_drained", 64'(exp_d_q.size() + exp_f_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
